camera_histogram: RTL and testbench

- Parametrised per-frame pixel histogram engine for the camera datapath; the successor to the fixed 12-bit/256-bin histogram memory.
- Bins the qualified camera pixel stream into 2**BIN_BITS saturating counters.
- Double-buffers the counters: one bank accumulates the current frame while the previous frame's bank is read over a NIOS/HPS-style acknowledge bus.
- Swaps banks at frame end, raises an interrupt, and packs BINS_PER_WORD bins per bus read.

---
 rtl/camera_histogram_pkg.sv | 26 ++
 rtl/camera_histogram_bank.sv | 87 ++++++++
 rtl/camera_histogram.sv | 191 +++++++++++++++++++
 tb/tb_camera_histogram.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_histogram_pkg.sv
// camera_histogram_pkg
//   Shared types and width helpers for the camera histogram engine.
//   - bank_t      : selects one of the two counter banks
//   - word_addr_w : bus word-address width for a given bin count / packing
//   - lane_w      : width of the bin-within-word select (never below 1)
//   - count_sat   : all-ones value of a counter of the given width
package camera_histogram_pkg;

  typedef logic bank_t;

  // Cycles from the vsync_q falling edge until the closed bank is published.
  localparam int PIPE_STAGES = 3;

  function automatic int word_addr_w(input int bin_bits, input int bins_per_word);
    return bin_bits - $clog2(bins_per_word);
  endfunction

  function automatic int lane_w(input int bins_per_word);
    return (bins_per_word > 1) ? $clog2(bins_per_word) : 1;
  endfunction

  function automatic logic [63:0] count_sat(input int count_w);
    return (count_w >= 64) ? '1 : ((64'd1 << count_w) - 64'd1);
  endfunction

endpackage

// File: rtl/camera_histogram_bank.sv
// histo_bank
//   One histogram counter bank: a dual-port RAM of packed bin words plus a
//   per-bin valid flop array. Invalid bins read as zero, so clearing the
//   whole bank is a single-cycle clear of the valid bits.
// Ports
//   clk, rst       : clock, async active-low reset (valid bits only)
//   clr            : clear every valid bit of this bank
//   a_raddr/a_rdata: accumulator read, one bin, 1-cycle latency
//   a_we/a_waddr/a_wdata : accumulator write of one bin, sets its valid bit
//   b_addr/b_rdata : reader port, one packed word, 1-cycle latency
module histo_bank
  import camera_histogram_pkg::*;
#(
  parameter int BIN_BITS      = 8,
  parameter int COUNT_W       = 32,
  parameter int BINS_PER_WORD = 2
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           clr,
  input  logic [BIN_BITS-1:0]                            a_raddr,
  output logic [COUNT_W-1:0]                             a_rdata,
  input  logic                                           a_we,
  input  logic [BIN_BITS-1:0]                            a_waddr,
  input  logic [COUNT_W-1:0]                             a_wdata,
  input  logic [word_addr_w(BIN_BITS, BINS_PER_WORD)-1:0] b_addr,
  output logic [BINS_PER_WORD*COUNT_W-1:0]               b_rdata
);

  localparam int WA_W      = word_addr_w(BIN_BITS, BINS_PER_WORD);
  localparam int LANE_W    = lane_w(BINS_PER_WORD);
  localparam int LANE_BITS = $clog2(BINS_PER_WORD);
  localparam int NWORDS    = 1 << WA_W;
  localparam int NBINS     = 1 << BIN_BITS;
  localparam int WORD_W    = BINS_PER_WORD * COUNT_W;

  logic [WORD_W-1:0]        mem [NWORDS];
  logic [NBINS-1:0]         valid;

  logic [WA_W-1:0]          a_wword, a_rword;
  logic [LANE_W-1:0]        a_wlane, a_rlane, a_lane_q;
  logic [WORD_W-1:0]        a_word_q, b_word_q;
  logic                     a_vld_q;
  logic [BINS_PER_WORD-1:0] b_vld_q;

  assign a_wword = WA_W'(a_waddr >> LANE_BITS);
  assign a_rword = WA_W'(a_raddr >> LANE_BITS);
  assign a_wlane = (BINS_PER_WORD > 1) ? LANE_W'(a_waddr) : '0;
  assign a_rlane = (BINS_PER_WORD > 1) ? LANE_W'(a_raddr) : '0;

  // RAM contents are never reset; the valid bits stand in for that.
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem[a_wword][a_wlane*COUNT_W +: COUNT_W] <= a_wdata;
    end
    a_word_q <= mem[a_rword];
    b_word_q <= mem[b_addr];
  end

  // A write in the same cycle as clr still marks its bin valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= '0;
      a_vld_q  <= 1'b0;
      a_lane_q <= '0;
      b_vld_q  <= '0;
    end else begin
      if (clr) begin
        valid <= '0;
      end
      if (a_we) begin
        valid[a_waddr] <= 1'b1;
      end
      a_vld_q  <= valid[a_raddr];
      a_lane_q <= a_rlane;
      b_vld_q  <= valid[b_addr*BINS_PER_WORD +: BINS_PER_WORD];
    end
  end

  assign a_rdata = a_vld_q ? a_word_q[a_lane_q*COUNT_W +: COUNT_W] : '0;

  for (genvar l = 0; l < BINS_PER_WORD; l++) begin : g_lane
    assign b_rdata[l*COUNT_W +: COUNT_W] =
      b_vld_q[l] ? b_word_q[l*COUNT_W +: COUNT_W] : '0;
  end

endmodule

// File: rtl/camera_histogram.sv
// camera_histogram
//   Per-frame pixel histogram with two counter banks. The active bank
//   accumulates qualified pixels through a 3-stage read-modify-write pipeline;
//   the ready bank (previous frame) is read over an acknowledge bus.
// Ports
//   clk, rst          : clock, async active-low reset
//   pix_in, pix_valid : pixel and strobe; accepted only while vsync_q is high
//   vsync             : frame-active level; its falling edge swaps banks
//   hm_*              : bus (reads return packed bins, writes are ignored)
//   irq, irq_clear    : frame-ready level interrupt and its clear pulse
//   frame_count       : completed frames, wrapping
//
// Bus FSM
//   state     | meaning
//   ST_IDLE   | waiting for a request
//   ST_RD1    | ready-bank word arriving from RAM, captured into hm_read_data
//   ST_RD2    | read acknowledge
//   ST_WR_ACK | write acknowledge (write itself discarded)
module camera_histogram
  import camera_histogram_pkg::*;
#(
  parameter int PIX_W         = 12,
  parameter int BIN_BITS      = 8,
  parameter int COUNT_W       = 32,
  parameter int BINS_PER_WORD = 2,
  parameter int FCNT_W        = 16
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [PIX_W-1:0]                               pix_in,
  input  logic                                           pix_valid,
  input  logic                                           vsync,
  input  logic                                           hm_bus_enable,
  input  logic                                           hm_rw,
  input  logic [word_addr_w(BIN_BITS, BINS_PER_WORD)-1:0] hm_address,
  output logic                                           hm_acknowledge,
  output logic [BINS_PER_WORD*COUNT_W-1:0]               hm_read_data,
  output logic                                           irq,
  input  logic                                           irq_clear,
  output logic [FCNT_W-1:0]                              frame_count
);

  localparam int WORD_W = BINS_PER_WORD * COUNT_W;
  localparam logic [COUNT_W-1:0] CNT_SAT = COUNT_W'(count_sat(COUNT_W));

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RD1    = 2'd1;
  localparam logic [1:0] ST_RD2    = 2'd2;
  localparam logic [1:0] ST_WR_ACK = 2'd3;

  // Frame timing
  logic vsync_q, vsync_prev, swap_edge, accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q    <= 1'b0;
      vsync_prev <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      vsync_prev <= vsync_q;
    end
  end

  assign swap_edge = vsync_prev & ~vsync_q;
  assign accept    = pix_valid & vsync_q;

  // Bank swap; publication waits for in-flight pixels of the closed bank.
  bank_t                      active_bank, ready_bank;
  logic [PIPE_STAGES-2:0]     swap_dly;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_bank <= 1'b0;
      ready_bank  <= 1'b1;
      swap_dly    <= '0;
      irq         <= 1'b0;
      frame_count <= '0;
    end else begin
      swap_dly <= {swap_dly[PIPE_STAGES-3:0], swap_edge};
      if (swap_edge) begin
        active_bank <= ~active_bank;
      end
      if (swap_dly[PIPE_STAGES-2]) begin
        ready_bank  <= ~active_bank;
        irq         <= 1'b1;
        frame_count <= frame_count + FCNT_W'(1);
      end else if (irq_clear) begin
        irq <= 1'b0;
      end
    end
  end

  // Accumulate pipeline
  logic                s0_valid, s1_valid, s2_valid;
  logic [BIN_BITS-1:0] s0_bin, s1_bin, s2_bin;
  bank_t               s0_bank, s1_bank, s2_bank;
  logic [COUNT_W-1:0]  s2_count, s1_base, s1_next;
  logic                fwd_hit;
  logic [COUNT_W-1:0]  a_rdata [2];
  logic [WORD_W-1:0]   b_rdata [2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_valid <= 1'b0;
      s0_bin   <= '0;
      s0_bank  <= 1'b0;
      s1_valid <= 1'b0;
      s1_bin   <= '0;
      s1_bank  <= 1'b0;
      s2_valid <= 1'b0;
      s2_bin   <= '0;
      s2_bank  <= 1'b0;
      s2_count <= '0;
    end else begin
      s0_valid <= accept;
      s0_bin   <= pix_in[PIX_W-1 -: BIN_BITS];
      s0_bank  <= active_bank;
      s1_valid <= s0_valid;
      s1_bin   <= s0_bin;
      s1_bank  <= s0_bank;
      s2_valid <= s1_valid;
      s2_bin   <= s1_bin;
      s2_bank  <= s1_bank;
      s2_count <= s1_next;
    end
  end

  // The RAM read for S1 was issued while the previous pixel was still being
  // written, so a back-to-back hit on the same bin takes the written value.
  assign fwd_hit = s2_valid && (s2_bank == s1_bank) && (s2_bin == s1_bin);
  assign s1_base = fwd_hit ? s2_count : a_rdata[s1_bank];
  assign s1_next = (s1_base == CNT_SAT) ? CNT_SAT : s1_base + COUNT_W'(1);

  for (genvar g = 0; g < 2; g++) begin : g_bank
    histo_bank #(
      .BIN_BITS      (BIN_BITS),
      .COUNT_W       (COUNT_W),
      .BINS_PER_WORD (BINS_PER_WORD)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .clr     (swap_edge && (active_bank != 1'(g))),
      .a_raddr (s0_bin),
      .a_rdata (a_rdata[g]),
      .a_we    (s1_valid && (s1_bank == 1'(g))),
      .a_waddr (s1_bin),
      .a_wdata (s1_next),
      .b_addr  (hm_address),
      .b_rdata (b_rdata[g])
    );
  end

  if (PIX_W > BIN_BITS) begin : g_unused_pix
    logic unused_pix_lsbs;
    assign unused_pix_lsbs = ^pix_in[PIX_W-BIN_BITS-1:0];
  end

  // Bus FSM. Both banks see hm_address every cycle; the bank captured at
  // accept picks which RAM output is kept.
  logic [1:0] state;
  bank_t      rd_bank;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      rd_bank      <= 1'b0;
      hm_read_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hm_bus_enable) begin
            if (hm_rw) begin
              state   <= ST_RD1;
              rd_bank <= ready_bank;
            end else begin
              state <= ST_WR_ACK;
            end
          end
        end
        ST_RD1: begin
          hm_read_data <= b_rdata[rd_bank];
          state        <= ST_RD2;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign hm_acknowledge = (state == ST_RD2) || (state == ST_WR_ACK);

endmodule

// File: tb/tb_camera_histogram.sv
module tb_camera_histogram;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pix_in;
  logic        pix_valid;
  logic        vsync;
  logic        hm_bus_enable;
  logic        hm_rw;
  logic [6:0]  hm_address;
  logic        irq_clear;

  logic        ack, ack_s;
  logic [63:0] rdata;
  logic [7:0]  rdata_s;
  logic        irq, irq_s;
  logic [15:0] fc, fc_s;

  int n_checks = 0;
  int n_err    = 0;
  int exp_fc   = 0;

  always #10 clk = ~clk;

  camera_histogram dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .vsync(vsync),
    .hm_bus_enable(hm_bus_enable), .hm_rw(hm_rw), .hm_address(hm_address),
    .hm_acknowledge(ack), .hm_read_data(rdata), .irq(irq), .irq_clear(irq_clear),
    .frame_count(fc)
  );

  camera_histogram #(.COUNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .vsync(vsync),
    .hm_bus_enable(hm_bus_enable), .hm_rw(hm_rw), .hm_address(hm_address),
    .hm_acknowledge(ack_s), .hm_read_data(rdata_s), .irq(irq_s), .irq_clear(irq_clear),
    .frame_count(fc_s)
  );

  // Reference model: per-frame bin tallies. A pixel counts when strobed while
  // vsync was high on the previous clock; when that delayed vsync drops, the
  // frame's tallies become the readable frame and the next frame starts empty.
  int unsigned cur_cnt [256];
  int unsigned rdy_cnt [256];
  logic        m_vq;

  always @(posedge clk) begin
    if (!rst) begin
      m_vq = 1'b0;
      foreach (cur_cnt[i]) begin
        cur_cnt[i] = 0;
        rdy_cnt[i] = 0;
      end
    end else begin
      if (pix_valid && m_vq) cur_cnt[pix_in[11:4]]++;
      if (m_vq && !vsync) begin
        rdy_cnt = cur_cnt;
        foreach (cur_cnt[i]) cur_cnt[i] = 0;
      end
      m_vq = vsync;
    end
  end

  function automatic logic [3:0] sat4(int unsigned c);
    return (c > 15) ? 4'd15 : 4'(c);
  endfunction

  function automatic logic [63:0] exp_word(int addr);
    return {32'(rdy_cnt[2*addr+1]), 32'(rdy_cnt[2*addr])};
  endfunction

  function automatic logic [7:0] exp_word_s(int addr);
    return {sat4(rdy_cnt[2*addr+1]), sat4(rdy_cnt[2*addr])};
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(logic [11:0] p, logic v);
    pix_in    = p;
    pix_valid = v;
    tick();
  endtask

  task automatic do_read(int addr, string tag);
    logic [63:0] e;
    logic [7:0]  es;
    e  = exp_word(addr);
    es = exp_word_s(addr);
    hm_bus_enable = 1'b1;
    hm_rw         = 1'b1;
    hm_address    = 7'(addr);
    tick();
    check({tag, " ack_early"}, ack, 0);
    tick();
    check({tag, " ack"}, ack, 1);
    check({tag, " data"}, rdata, e);
    check({tag, " ack_sat"}, ack_s, 1);
    check({tag, " data_sat"}, rdata_s, es);
    hm_bus_enable = 1'b0;
    tick();
    check({tag, " ack_end"}, ack, 0);
  endtask

  task automatic clear_irq();
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    check("irq_clear", irq, 0);
  endtask

  task automatic start_frame();
    vsync = 1'b1;
    pix(12'h070, 1'b1);   // vsync_q still low here: must be dropped
  endtask

  task automatic end_frame(string tag);
    vsync     = 1'b0;
    pix_valid = 1'b0;
    exp_fc++;
    tick();
    tick();
    tick();
    check({tag, " irq_pre"}, irq, 0);
    tick();
    check({tag, " irq"}, irq, 1);
    check({tag, " irq_sat"}, irq_s, 1);
    check({tag, " fcount"}, fc, 16'(exp_fc));
    check({tag, " fcount_sat"}, fc_s, 16'(exp_fc));
  endtask

  function automatic logic [11:0] rnd_pix_avoid();
    logic [11:0] p;
    do p = 12'($urandom_range(0, 4095));
    while (p[11:4] == 8'h00 || p[11:4] == 8'h07 || p[11:4] == 8'hFF || p[11:4] == 8'hAB);
    return p;
  endfunction

  initial begin
    logic [63:0] e_ov;
    logic [7:0]  es_ov;

    rst = 1'b0; pix_in = '0; pix_valid = 1'b0; vsync = 1'b0;
    hm_bus_enable = 1'b0; hm_rw = 1'b0; hm_address = '0; irq_clear = 1'b0;
    tick(); tick(); tick();
    check("rst irq", irq, 0);
    check("rst fcount", fc, 0);
    check("rst ack", ack, 0);
    check("rst rdata", rdata, 0);
    rst = 1'b1;
    tick();

    // Pixels outside frame-active are dropped
    for (int i = 0; i < 5; i++) pix(12'($urandom_range(0, 4095)), 1'b1);

    // Frame 1: 1000 x 0x123, 50 pixels in bin 7
    start_frame();
    for (int i = 0; i < 1000; i++) pix(12'h123, 1'b1);
    for (int i = 0; i < 50; i++) pix({8'h07, 4'($urandom_range(0, 15))}, 1'b1);
    end_frame("f1");
    do_read(9, "f1 rd9");
    check("f1 bin12", rdata[31:0], 1000);
    check("f1 bin13", rdata[63:32], 0);
    check("f1 bin12 sat", rdata_s[3:0], 15);
    do_read(3, "f1 rd3");
    check("f1 bin7", rdata[63:32], 50);

    // Writes are acknowledged after one cycle and change nothing
    hm_bus_enable = 1'b1; hm_rw = 1'b0; hm_address = 7'd9;
    tick();
    check("wr ack", ack, 1);
    check("wr ack sat", ack_s, 1);
    hm_bus_enable = 1'b0;
    tick();
    check("wr ack_end", ack, 0);
    do_read(9, "f1 rd9 after wr");

    clear_irq();

    // Frame 2: back-to-back same-bin pattern, 5 in bin 7, random filler,
    // 20 identical pixels for the 4-bit saturation instance
    start_frame();
    pix(12'h000, 1'b1); pix(12'h000, 1'b1); pix(12'hFFF, 1'b1); pix(12'h000, 1'b1);
    for (int i = 0; i < 5; i++) pix(12'h075, 1'b1);
    for (int i = 0; i < 200; i++) pix(rnd_pix_avoid(), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 20; i++) pix(12'hABC, 1'b1);
    end_frame("f2");
    for (int a = 0; a < 128; a++) do_read(a, $sformatf("f2 rd%0d", a));
    do_read(0, "f2 rd0");
    check("f2 bin0", rdata[31:0], 3);
    do_read(127, "f2 rd127");
    check("f2 binFF", rdata[63:32], 1);
    do_read(3, "f2 rd3");
    check("f2 bin7", rdata[63:32], 5);
    do_read(85, "f2 rd85");
    check("f2 binAB sat", rdata_s[7:4], 15);
    check("f2 binAB", rdata[63:32], 20);

    clear_irq();

    // Frame 3: random; a read is accepted in the same cycle vsync drops,
    // which also carries the frame's last pixel
    start_frame();
    for (int i = 0; i < 300; i++)
      pix(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 3) != 0));
    e_ov  = exp_word(3);
    es_ov = exp_word_s(3);
    vsync = 1'b0; pix_in = 12'h070; pix_valid = 1'b1;
    hm_bus_enable = 1'b1; hm_rw = 1'b1; hm_address = 7'd3;
    exp_fc++;
    tick();
    pix_valid = 1'b0;
    check("ov ack_early", ack, 0);
    tick();
    check("ov ack", ack, 1);
    check("ov data", rdata, e_ov);
    check("ov data_sat", rdata_s, es_ov);
    hm_bus_enable = 1'b0;
    tick();
    check("ov irq_pre", irq, 0);
    tick();
    check("ov irq", irq, 1);
    check("ov fcount", fc, 16'(exp_fc));
    do_read(3, "f3 rd3");
    for (int a = 0; a < 128; a += 9) do_read(a, $sformatf("f3 rd%0d", a));

    // Reset in the middle of a read while irq is pending
    check("pre-rst irq", irq, 1);
    hm_bus_enable = 1'b1; hm_rw = 1'b1; hm_address = 7'd9;
    tick();
    rst = 1'b0;
    #1;
    check("mid-rst irq", irq, 0);
    check("mid-rst fcount", fc, 0);
    check("mid-rst ack", ack, 0);
    check("mid-rst rdata", rdata, 0);
    tick();
    check("mid-rst ack1", ack, 0);
    tick();
    check("mid-rst ack2", ack, 0);
    hm_bus_enable = 1'b0;
    rst = 1'b1;
    tick();
    do_read(9, "post-rst rd9");
    check("post-rst data", rdata, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
